// File: rtl/axi_ni_receive_request_fsm.sv
// axi_ni_receive_request_fsm
// Request side of the target NI receive path. It takes request flits from the NoC
// input buffer and decodes HEAD flits into AXI address/control fields. It then
// sequences one AXI transaction at a time through active-high channel masks (a
// channel's VALID is the inverse of its mask). Write beats are presented one at a
// time with strobe and last-beat flag.
//
// Optional build macro: NI_RX_PROTOCOL_CHECK_EN
//   When defined, mis-typed flits are consumed and dropped, and a sticky
//   protocol_error is raised. When undefined, the flit type is ignored and
//   protocol_error is tied low.
module axi_ni_receive_request_fsm #(
  parameter int unsigned FLIT_WIDTH = 64,
  parameter int unsigned AXIADDRWD  = 32,
  parameter int unsigned AXIWDATAWD = 32,
  parameter int unsigned AXIIDWD    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FLIT_WIDTH-1:0]     flit_in,
  input  logic                      flit_valid,
  output logic                      flit_ready,
  input  logic                      AWREADY,
  input  logic                      ARREADY,
  input  logic                      WREADY,
  output logic                      mask_aw_command,
  output logic                      mask_ar_command,
  output logic                      mask_wd_command,
  output logic [AXIIDWD-1:0]        received_id,
  output logic [AXIADDRWD-1:0]      received_address,
  output logic [AXIWDATAWD-1:0]     received_data,
  output logic [3:0]                decoded_LEN,
  output logic [2:0]                decoded_SIZE,
  output logic [1:0]                decoded_BURST,
  output logic [1:0]                decoded_LOCK,
  output logic [3:0]                decoded_CACHE,
  output logic [2:0]                decoded_PROT,
  output logic [AXIWDATAWD/8-1:0]   decoded_WSTRB,
  output logic                      wlast,
  output logic                      protocol_error
);

  localparam int STRBWD = AXIWDATAWD / 8;

  // Header field positions, packed downward from the type field.
  localparam int TYPE_HI  = FLIT_WIDTH - 1;
  localparam int CMD_BIT  = FLIT_WIDTH - 3;
  localparam int ID_HI    = FLIT_WIDTH - 4;
  localparam int LEN_HI   = ID_HI - AXIIDWD;
  localparam int SIZE_HI  = LEN_HI - 4;
  localparam int BURST_HI = SIZE_HI - 3;
  localparam int LOCK_HI  = BURST_HI - 2;
  localparam int CACHE_HI = LOCK_HI - 2;
  localparam int PROT_HI  = CACHE_HI - 4;
  localparam int ADDR_HI  = PROT_HI - 3;
  localparam int ADDR_LO  = ADDR_HI - AXIADDRWD + 1;

  // Data flit field positions.
  localparam int STRB_HI  = FLIT_WIDTH - 3;
  localparam int DATA_HI  = STRB_HI - STRBWD;
  localparam int DATA_LO  = DATA_HI - AXIWDATAWD + 1;

  // Lowest flit bit that any flit format actually uses.
  localparam int LOW_USED = (ADDR_LO < DATA_LO) ? ADDR_LO : DATA_LO;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] AR_REQ  = 3'd1;
  localparam logic [2:0] AW_REQ  = 3'd2;
  localparam logic [2:0] W_WAIT  = 3'd3;
  localparam logic [2:0] W_DRIVE = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;

  logic                   flit_ready_d;
  logic                   mask_aw_d, mask_ar_d, mask_wd_d;
  logic [AXIIDWD-1:0]     id_d;
  logic [AXIADDRWD-1:0]   addr_d;
  logic [AXIWDATAWD-1:0]  data_d;
  logic [3:0]             len_d;
  logic [2:0]             size_d;
  logic [1:0]             burst_d;
  logic [1:0]             lock_d;
  logic [3:0]             cache_d;
  logic [2:0]             prot_d;
  logic [STRBWD-1:0]      strb_d;
  logic                   wlast_d;

  logic                   flit_fire;
  logic                   is_last;
  logic                   head_ok;
  logic                   data_ok;

  assign flit_fire = flit_valid & flit_ready;
  // The counter never runs past decoded_LEN, so LEN=15 finishes at count 15.
  assign is_last   = (beat_cnt_q == decoded_LEN);

`ifdef NI_RX_PROTOCOL_CHECK_EN
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_BODY = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  logic [1:0] flit_type;
  assign flit_type = flit_in[TYPE_HI -: 2];

  // Anything other than a HEAD in IDLE (reserved included) is treated as stray.
  assign head_ok = (flit_type == TYPE_HEAD);
  assign data_ok = is_last ? (flit_type == TYPE_TAIL) : (flit_type == TYPE_BODY);

  // Sticky error: set whenever a mis-typed flit is consumed and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_error <= 1'b0;
    end else if (flit_fire && (((state_q == IDLE) && !head_ok) ||
                               ((state_q == W_WAIT) && !data_ok))) begin
      protocol_error <= 1'b1;
    end
  end
`else
  logic unused_type;
  assign unused_type    = ^flit_in[TYPE_HI -: 2];
  assign head_ok        = 1'b1;
  assign data_ok        = 1'b1;
  assign protocol_error = 1'b0;
`endif

  if (LOW_USED > 0) begin : g_unused_low
    logic unused_low;
    assign unused_low = ^flit_in[LOW_USED-1:0];
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    mask_aw_d  = mask_aw_command;
    mask_ar_d  = mask_ar_command;
    mask_wd_d  = mask_wd_command;
    id_d       = received_id;
    addr_d     = received_address;
    data_d     = received_data;
    len_d      = decoded_LEN;
    size_d     = decoded_SIZE;
    burst_d    = decoded_BURST;
    lock_d     = decoded_LOCK;
    cache_d    = decoded_CACHE;
    prot_d     = decoded_PROT;
    strb_d     = decoded_WSTRB;
    wlast_d    = wlast;

    case (state_q)
      IDLE: begin
        if (flit_fire && head_ok) begin
          id_d       = flit_in[ID_HI -: AXIIDWD];
          len_d      = flit_in[LEN_HI -: 4];
          size_d     = flit_in[SIZE_HI -: 3];
          burst_d    = flit_in[BURST_HI -: 2];
          lock_d     = flit_in[LOCK_HI -: 2];
          cache_d    = flit_in[CACHE_HI -: 4];
          prot_d     = flit_in[PROT_HI -: 3];
          addr_d     = flit_in[ADDR_HI -: AXIADDRWD];
          beat_cnt_d = 4'd0;
          if (flit_in[CMD_BIT]) begin
            state_d   = AW_REQ;
            mask_aw_d = 1'b0;
          end else begin
            state_d   = AR_REQ;
            mask_ar_d = 1'b0;
          end
        end
      end
      AR_REQ: begin
        if (ARREADY && !mask_ar_command) begin
          mask_ar_d = 1'b1;
          state_d   = IDLE;
        end
      end
      AW_REQ: begin
        if (AWREADY && !mask_aw_command) begin
          mask_aw_d = 1'b1;
          state_d   = W_WAIT;
        end
      end
      W_WAIT: begin
        if (flit_fire && data_ok) begin
          data_d    = flit_in[DATA_HI -: AXIWDATAWD];
          strb_d    = flit_in[STRB_HI -: STRBWD];
          wlast_d   = is_last;
          mask_wd_d = 1'b0;
          state_d   = W_DRIVE;
        end
      end
      W_DRIVE: begin
        if (WREADY && !mask_wd_command) begin
          mask_wd_d = 1'b1;
          wlast_d   = 1'b0;
          if (wlast) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            state_d    = W_WAIT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Flit acceptance is open only in the states that consume flits.
  assign flit_ready_d = (state_d == IDLE) || (state_d == W_WAIT);

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      beat_cnt_q       <= 4'd0;
      flit_ready       <= 1'b0;
      mask_aw_command  <= 1'b1;
      mask_ar_command  <= 1'b1;
      mask_wd_command  <= 1'b1;
      received_id      <= '0;
      received_address <= '0;
      received_data    <= '0;
      decoded_LEN      <= '0;
      decoded_SIZE     <= '0;
      decoded_BURST    <= '0;
      decoded_LOCK     <= '0;
      decoded_CACHE    <= '0;
      decoded_PROT     <= '0;
      decoded_WSTRB    <= '0;
      wlast            <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      flit_ready       <= flit_ready_d;
      mask_aw_command  <= mask_aw_d;
      mask_ar_command  <= mask_ar_d;
      mask_wd_command  <= mask_wd_d;
      received_id      <= id_d;
      received_address <= addr_d;
      received_data    <= data_d;
      decoded_LEN      <= len_d;
      decoded_SIZE     <= size_d;
      decoded_BURST    <= burst_d;
      decoded_LOCK     <= lock_d;
      decoded_CACHE    <= cache_d;
      decoded_PROT     <= prot_d;
      decoded_WSTRB    <= strb_d;
      wlast            <= wlast_d;
    end
  end

endmodule

// File: tb/tb_axi_ni_receive_request_fsm.sv
// Bench for axi_ni_receive_request_fsm: cycle-by-cycle vector table for the
// main read/write flows, then hand-written sequences for AW back-pressure with
// a 16-beat burst, asynchronous reset mid-burst and, when
// NI_RX_PROTOCOL_CHECK_EN is defined, the stray-flit error path.
module tb_axi_ni_receive_request_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;
  logic        AWREADY, ARREADY, WREADY;
  logic        mask_aw_command, mask_ar_command, mask_wd_command;
  logic [3:0]  received_id;
  logic [31:0] received_address;
  logic [31:0] received_data;
  logic [3:0]  decoded_LEN;
  logic [2:0]  decoded_SIZE;
  logic [1:0]  decoded_BURST;
  logic [1:0]  decoded_LOCK;
  logic [3:0]  decoded_CACHE;
  logic [2:0]  decoded_PROT;
  logic [3:0]  decoded_WSTRB;
  logic        wlast;
  logic        protocol_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_ni_receive_request_fsm dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flit_in          (flit_in),
    .flit_valid       (flit_valid),
    .flit_ready       (flit_ready),
    .AWREADY          (AWREADY),
    .ARREADY          (ARREADY),
    .WREADY           (WREADY),
    .mask_aw_command  (mask_aw_command),
    .mask_ar_command  (mask_ar_command),
    .mask_wd_command  (mask_wd_command),
    .received_id      (received_id),
    .received_address (received_address),
    .received_data    (received_data),
    .decoded_LEN      (decoded_LEN),
    .decoded_SIZE     (decoded_SIZE),
    .decoded_BURST    (decoded_BURST),
    .decoded_LOCK     (decoded_LOCK),
    .decoded_CACHE    (decoded_CACHE),
    .decoded_PROT     (decoded_PROT),
    .decoded_WSTRB    (decoded_WSTRB),
    .wlast            (wlast),
    .protocol_error   (protocol_error)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } hdr_t;

  typedef struct {
    logic [63:0] flit;
    logic        fv, awr, arr, wr;
    logic [4:0]  ctl;  // {flit_ready, mask_aw, mask_ar, mask_wd, wlast}
    hdr_t        h;
    logic [31:0] d;
    logic [3:0]  s;
  } vec_t;

  localparam logic [4:0] C_RDY = 5'b11110;
  localparam logic [4:0] C_AR  = 5'b01010;
  localparam logic [4:0] C_AW  = 5'b00110;
  localparam logic [4:0] C_WD  = 5'b01100;
  localparam logic [4:0] C_WDL = 5'b01101;

  vec_t vecs[$];

  function automatic logic [63:0] mkhead(input logic cmd, input hdr_t h);
    logic [63:0] f;
    f        = '0;
    f[63:62] = 2'b01;
    f[61]    = cmd;
    f[60:57] = h.id;
    f[56:53] = h.len;
    f[52:50] = h.size;
    f[49:48] = h.burst;
    f[47:46] = h.lock;
    f[45:42] = h.cache;
    f[41:39] = h.prot;
    f[38:7]  = h.addr;
    f[6:0]   = 7'h55;  // padding that must be ignored
    return f;
  endfunction

  function automatic logic [63:0] mkdata(input logic tail, input logic [3:0] s,
                                         input logic [31:0] d);
    logic [63:0] f;
    f        = '0;
    f[63:62] = tail ? 2'b11 : 2'b10;
    f[61:58] = s;
    f[57:26] = d;
    f[25:0]  = 26'h2AA_AAAA;
    return f;
  endfunction

  function automatic vec_t row(input logic [63:0] f, input logic fv, input logic awr,
                               input logic arr, input logic wr, input logic [4:0] ctl,
                               input hdr_t h, input logic [31:0] d, input logic [3:0] s);
    vec_t v;
    v.flit = f; v.fv = fv; v.awr = awr; v.arr = arr; v.wr = wr;
    v.ctl = ctl; v.h = h; v.d = d; v.s = s;
    return v;
  endfunction

  function automatic logic [4:0] dut_ctl();
    return {flit_ready, mask_aw_command, mask_ar_command, mask_wd_command, wlast};
  endfunction

  function automatic hdr_t dut_hdr();
    return {received_id, received_address, decoded_LEN, decoded_SIZE, decoded_BURST,
            decoded_LOCK, decoded_CACHE, decoded_PROT};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write beat from W_WAIT: accept the data flit, then complete the W handshake.
  task automatic write_beat(input logic last, input logic [31:0] d, input logic [3:0] s);
    flit_in    = mkdata(last, s, d);
    flit_valid = 1'b1;
    step();
    flit_valid = 1'b0;
    chk("beat_valid", dut_ctl(), last ? C_WDL : C_WD);
    chk("beat_data", {received_data, decoded_WSTRB}, {d, s});
    WREADY = 1'b1;
    step();
    WREADY = 1'b0;
    chk("beat_done", dut_ctl(), C_RDY);
  endtask

  hdr_t h0, h1, h2, h3, h4, h5, h6, h7;
  int   low_cnt;

  initial begin
    h0 = '0;
    h1 = '{id: 4'h3, addr: 32'h1000_0040, len: 4'd0, size: 3'd2, burst: 2'd1,
           lock: 2'd0, cache: 4'h3, prot: 3'd2};
    h2 = '{id: 4'h5, addr: 32'h2000_0100, len: 4'd3, size: 3'd2, burst: 2'd1,
           lock: 2'd1, cache: 4'h2, prot: 3'd1};
    h3 = '{id: 4'h9, addr: 32'h3000_0008, len: 4'd0, size: 3'd1, burst: 2'd2,
           lock: 2'd2, cache: 4'hA, prot: 3'd5};
    h4 = '{id: 4'hC, addr: 32'h4000_0080, len: 4'd15, size: 3'd2, burst: 2'd1,
           lock: 2'd0, cache: 4'h0, prot: 3'd0};
    h5 = '{id: 4'h6, addr: 32'h5000_0000, len: 4'd7, size: 3'd2, burst: 2'd1,
           lock: 2'd0, cache: 4'h1, prot: 3'd3};
    h6 = '{id: 4'h7, addr: 32'h6000_0004, len: 4'd0, size: 3'd0, burst: 2'd0,
           lock: 2'd1, cache: 4'h5, prot: 3'd4};
    h7 = '{id: 4'h2, addr: 32'h7000_0010, len: 4'd0, size: 3'd2, burst: 2'd1,
           lock: 2'd0, cache: 4'h0, prot: 3'd0};

    // Each row: inputs before an edge, registered outputs expected after it.
    vecs.push_back(row(64'h0, 0, 0, 0, 0, C_RDY, h0, 32'h0, 4'h0));
    vecs.push_back(row(mkhead(1'b0, h1), 1, 0, 1, 0, C_AR, h1, 32'h0, 4'h0));
    vecs.push_back(row(64'h0, 0, 0, 1, 0, C_RDY, h1, 32'h0, 4'h0));
    vecs.push_back(row(mkhead(1'b1, h2), 1, 1, 1, 0, C_AW, h2, 32'h0, 4'h0));
    vecs.push_back(row(mkdata(1'b0, 4'hF, 32'hA0), 1, 1, 1, 0, C_RDY, h2, 32'h0, 4'h0));
    vecs.push_back(row(mkdata(1'b0, 4'hF, 32'hA0), 1, 0, 0, 1, C_WD, h2, 32'hA0, 4'hF));
    vecs.push_back(row(64'h0, 0, 0, 0, 0, C_WD, h2, 32'hA0, 4'hF));
    vecs.push_back(row(64'h0, 0, 0, 0, 1, C_RDY, h2, 32'hA0, 4'hF));
    vecs.push_back(row(64'h0, 0, 0, 0, 1, C_RDY, h2, 32'hA0, 4'hF));
    vecs.push_back(row(mkdata(1'b0, 4'hF, 32'hA1), 1, 0, 0, 1, C_WD, h2, 32'hA1, 4'hF));
    vecs.push_back(row(mkdata(1'b0, 4'hF, 32'hA2), 1, 0, 0, 1, C_RDY, h2, 32'hA1, 4'hF));
    vecs.push_back(row(mkdata(1'b0, 4'hF, 32'hA2), 1, 0, 0, 1, C_WD, h2, 32'hA2, 4'hF));
    vecs.push_back(row(64'h0, 0, 0, 0, 1, C_RDY, h2, 32'hA2, 4'hF));
    vecs.push_back(row(mkdata(1'b1, 4'hF, 32'hA3), 1, 0, 0, 1, C_WDL, h2, 32'hA3, 4'hF));
    vecs.push_back(row(64'h0, 0, 0, 0, 1, C_RDY, h2, 32'hA3, 4'hF));
    vecs.push_back(row(mkhead(1'b1, h3), 1, 0, 0, 0, C_AW, h3, 32'hA3, 4'hF));
    vecs.push_back(row(64'h0, 0, 0, 0, 0, C_AW, h3, 32'hA3, 4'hF));
    vecs.push_back(row(64'h0, 0, 1, 0, 0, C_RDY, h3, 32'hA3, 4'hF));
    vecs.push_back(row(mkdata(1'b1, 4'h3, 32'h55), 1, 0, 0, 0, C_WDL, h3, 32'h55, 4'h3));
    vecs.push_back(row(64'h0, 0, 0, 0, 1, C_RDY, h3, 32'h55, 4'h3));

    rst_n = 1'b0; flit_in = '0; flit_valid = 1'b0;
    AWREADY = 1'b0; ARREADY = 1'b0; WREADY = 1'b0;
    step();
    step();
    chk("reset_ctl", dut_ctl(), 5'b01110);
    chk("reset_hdr", dut_hdr(), h0);
    chk("reset_data", {received_data, decoded_WSTRB}, 36'h0);
    chk("reset_perr", protocol_error, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      flit_in = vecs[i].flit; flit_valid = vecs[i].fv;
      AWREADY = vecs[i].awr; ARREADY = vecs[i].arr; WREADY = vecs[i].wr;
      step();
      chk($sformatf("row%0d", i), {dut_ctl(), dut_hdr(), received_data, decoded_WSTRB},
          {vecs[i].ctl, vecs[i].h, vecs[i].d, vecs[i].s});
    end
    flit_valid = 1'b0; AWREADY = 1'b0; ARREADY = 1'b0; WREADY = 1'b0;

    // AWREADY held low for 5 cycles, then a full 16-beat burst.
    flit_in = mkhead(1'b1, h4); flit_valid = 1'b1;
    step();
    low_cnt = (mask_aw_command == 1'b0) ? 1 : 0;
    flit_in = mkdata(1'b0, 4'hF, 32'hDEAD_0000);
    for (int k = 0; k < 5; k++) begin
      step();
      if (mask_aw_command == 1'b0) low_cnt++;
      chk("stall_ready", flit_ready, 1'b0);
      chk("stall_addr", received_address, h4.addr);
    end
    flit_valid = 1'b0; AWREADY = 1'b1;
    step();
    AWREADY = 1'b0;
    chk("stall_low_cycles", low_cnt, 6);
    chk("stall_release", dut_ctl(), C_RDY);
    for (int k = 0; k < 16; k++) begin
      write_beat(k == 15, 32'hB000_0000 + 32'(k), 4'(k));
    end
    chk("len15_hdr", dut_hdr(), h4);

    // Asynchronous reset during the third beat of a len=7 write.
    flit_in = mkhead(1'b1, h5); flit_valid = 1'b1; AWREADY = 1'b1;
    step();
    flit_valid = 1'b0;
    step();
    AWREADY = 1'b0;
    write_beat(1'b0, 32'hC0, 4'hF);
    write_beat(1'b0, 32'hC1, 4'hF);
    flit_in = mkdata(1'b0, 4'hF, 32'hC2); flit_valid = 1'b1;
    step();
    flit_valid = 1'b0;
    chk("rst_pre", dut_ctl(), C_WD);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", dut_ctl(), 5'b01110);
    chk("rst_async_hdr", dut_hdr(), h0);
    chk("rst_async_data", {received_data, decoded_WSTRB}, 36'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_idle", dut_ctl(), C_RDY);
    flit_in = mkhead(1'b0, h6); flit_valid = 1'b1;
    step();
    flit_valid = 1'b0; ARREADY = 1'b1;
    chk("post_rst_ar", dut_ctl(), C_AR);
    chk("post_rst_hdr", dut_hdr(), h6);
    step();
    ARREADY = 1'b0;
    chk("post_rst_done", dut_ctl(), C_RDY);

`ifdef NI_RX_PROTOCOL_CHECK_EN
    chk("perr_clear", protocol_error, 1'b0);
    flit_in = mkdata(1'b0, 4'hF, 32'hDEAD); flit_valid = 1'b1;
    step();
    flit_valid = 1'b0;
    chk("perr_drop_ctl", dut_ctl(), C_RDY);
    chk("perr_drop_hdr", dut_hdr(), h6);
    chk("perr_set", protocol_error, 1'b1);
    flit_in = mkhead(1'b0, h7); flit_valid = 1'b1; ARREADY = 1'b1;
    step();
    flit_valid = 1'b0;
    chk("perr_read_ar", dut_ctl(), C_AR);
    step();
    ARREADY = 1'b0;
    chk("perr_read_done", dut_ctl(), C_RDY);
    chk("perr_sticky", protocol_error, 1'b1);
`else
    chk("perr_tied", protocol_error, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_ni_receive_request_fsm.md
Name: axi_ni_receive_request_fsm

Overview:
- Upstream stage of the target NI receive path, between the NoC input buffer and the AXI pinout masking stage.
- Accepts request flits and decodes each header into a command ID, address and AXI control fields.
- Sequences one AXI transaction at a time, driving active-high mask_aw/ar/wd_command; a channel's VALID is asserted only where its mask is low.
- Collects write-data flits one beat at a time and presents each beat with its strobe and a last-beat flag.

Parameters:
- FLIT_WIDTH, 64, flit width in bits; must be at least 57.
- AXIADDRWD, 32, request address width.
- AXIWDATAWD, 32, write data width; strobe width is AXIWDATAWD/8.
- AXIIDWD, 4, transaction ID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flit_in  in  FLIT_WIDTH  request flit from NoC buffer
- flit_valid  in  1  flit_in valid
- flit_ready  out  1  flit consumed when flit_valid&flit_ready
- AWREADY  in  1  AXI write-address ready
- ARREADY  in  1  AXI read-address ready
- WREADY  in  1  AXI write-data ready
- mask_aw_command  out  1  1 = AW channel idle
- mask_ar_command  out  1  1 = AR channel idle
- mask_wd_command  out  1  1 = W channel idle
- received_id  out  AXIIDWD  latched header ID
- received_address  out  AXIADDRWD  latched header address
- received_data  out  AXIWDATAWD  current write beat data
- decoded_LEN  out  4  burst length minus one
- decoded_SIZE  out  3  beat size
- decoded_BURST  out  2  burst type
- decoded_LOCK  out  2  lock
- decoded_CACHE  out  4  cache
- decoded_PROT  out  3  prot
- decoded_WSTRB  out  AXIWDATAWD/8  current beat strobe
- wlast  out  1  current W beat is the last beat
- protocol_error  out  1  sticky error (optional feature only; otherwise tied 0)

Behaviour:
- Flit type field is flit_in[FLIT_WIDTH-1 -: 2]: 01 HEAD, 10 BODY, 11 TAIL, 00 reserved.
- HEAD layout, from the type field downward:
  - cmd (1 = write, 0 = read)
  - id[AXIIDWD]
  - len[4], size[3], burst[2], lock[2], cache[4], prot[3]
  - addr[AXIADDRWD], ending at bit 0 of the used region; remaining low bits ignored.
- BODY/TAIL layout, from the type field downward: wstrb[AXIWDATAWD/8], then data[AXIWDATAWD].
- All outputs are registered.
- Reset values:
  - all three masks 1
  - flit_ready 0
  - all data, ID, address and decoded fields 0
  - wlast 0, protocol_error 0
  - state IDLE, beat counter 0
- States and transitions:
  - IDLE: flit_ready=1. On HEAD acceptance, latch all header fields and clear the beat counter; go to AR_REQ if cmd=0, else AW_REQ.
  - AR_REQ: mask_ar_command=0 and flit_ready=0. On ARREADY, set mask_ar_command=1 and go to IDLE.
  - AW_REQ: mask_aw_command=0. On AWREADY, set mask_aw_command=1 and go to W_WAIT.
  - W_WAIT: flit_ready=1. On BODY/TAIL acceptance, latch data and strobe, set wlast=(counter==decoded_LEN), set mask_wd_command=0, go to W_DRIVE.
  - W_DRIVE: flit_ready=0. On WREADY, set mask_wd_command=1 and wlast=0. If the beat was last, go to IDLE; else increment the counter and return to W_WAIT.
- Latency: a flit accepted at edge N gives its VALID (mask low) from cycle N+1.
- A VALID/mask stays stable until its READY is seen.
- Readiness:
  - The READY of a channel whose mask is 1 is ignored.
  - A READY already high in the first VALID cycle completes the handshake in one cycle.
- Minimum throughput:
  - reads: one per 2 cycles
  - writes: 2 + 2*(LEN+1) cycles
- LEN=0 is a single beat with wlast=1 on the first beat. LEN=15 gives 16 beats; the counter must not wrap before completion.
- Latched header fields hold from the header through the last handshake and are not cleared on return to IDLE.
- An asynchronous rst_n assertion mid-burst returns to reset values immediately; the partial transaction is abandoned.

Optional Feature:
- Macro: NI_RX_PROTOCOL_CHECK_EN.
- Defined:
  - A BODY/TAIL in IDLE, HEAD or reserved type in W_WAIT, or TAIL on a non-last beat (or BODY on the last beat) is accepted and dropped, state unchanged.
  - Each such event sets protocol_error, which holds until reset.
- Undefined:
  - In IDLE every flit is decoded as HEAD; in W_WAIT every flit is treated as data, with BODY and TAIL equivalent.
  - protocol_error is tied 0.

Test Plan:
- Read HEAD (id=3, addr=0x1000_0040, len=0, size=2) with ARREADY held 1 -> mask_ar_command low exactly one cycle, received_id=3, received_address=0x10000040, next flit accepted one cycle later.
- Write HEAD (len=3) plus four data flits 0xA0..0xA3 (strb 0xF), WREADY high -> four W handshakes in order, wlast only on 0xA3, mask_aw_command low one cycle before the first beat.
- AWREADY held low 5 cycles -> mask_aw_command stays low 6 cycles, received_address stable, flit_ready=0 throughout.
- Write len=0, data 0x55, strb 0x3 -> single beat with wlast=1, decoded_WSTRB=0x3, return to IDLE.
- rst_n pulsed low during the third beat of a len=7 write -> masks all 1 and fields 0 asynchronously; a new read HEAD is served normally after release.
- With NI_RX_PROTOCOL_CHECK_EN: BODY flit in IDLE -> consumed, protocol_error=1 and sticky, the following valid read completes.
